// File: rtl/board_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : board_mem_arbiter
// Description : Shares the single-port board RAM between the VGA render path
//               (always wins) and the game logic (free cycles, blanking only).
// Revision    : 1.0 - initial release
// ============================================================================
module board_mem_arbiter #(
  parameter int H_ACTIVE     = 800,
  parameter int V_ACTIVE     = 600,
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 6,
  parameter int ALLOW_ACTIVE = 0,
  parameter int WAIT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [10:0]       i_x,
  input  logic [9:0]        i_y,
  input  logic              i_render_req,
  input  logic [ADDR_W-1:0] i_render_addr,
  output logic              o_render_valid,
  output logic [DATA_W-1:0] o_render_data,
  input  logic              i_game_req,
  input  logic              i_game_we,
  input  logic [ADDR_W-1:0] i_game_addr,
  input  logic [DATA_W-1:0] i_game_wdata,
  output logic              o_game_ack,
  output logic [DATA_W-1:0] o_game_rdata,
  output logic [WAIT_W-1:0] o_game_max_wait,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_we,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata
);

  localparam logic [10:0] c_h_active = 11'(H_ACTIVE);
  localparam logic [9:0]  c_v_active = 10'(V_ACTIVE);
  localparam logic        c_allow    = (ALLOW_ACTIVE != 0);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_WAIT_RD = 2'd2,
    S_ACKED   = 2'd3
  } state_t;

  state_t              r_state;
  logic                r_g_we;
  logic                r_rtag0, r_rtag1;
  logic                r_gtag0, r_gtag1;
  logic                r_render_valid;
  logic [DATA_W-1:0]   r_render_data;
  logic                r_game_ack;
  logic [DATA_W-1:0]   r_game_rdata;
  logic [WAIT_W-1:0]   r_wait_cnt;
  logic [WAIT_W-1:0]   r_max_wait;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic                r_mem_we;
  logic [DATA_W-1:0]   r_mem_wdata;

  logic w_active;
  logic w_game_ok;
  logic w_game_pend;
  logic w_render_grant;
  logic w_game_grant;

  assign w_active       = (i_x < c_h_active) && (i_y < c_v_active);
  assign w_game_ok      = ~w_active | c_allow;
  // Masking with the ack pulse keeps a still-held request from being re-granted.
  assign w_game_pend    = i_game_req & ~r_game_ack;
  assign w_render_grant = i_render_req;
  assign w_game_grant   = ~i_render_req & w_game_pend & w_game_ok & (r_state == S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_g_we         <= 1'b0;
      r_rtag0        <= 1'b0;
      r_rtag1        <= 1'b0;
      r_gtag0        <= 1'b0;
      r_gtag1        <= 1'b0;
      r_render_valid <= 1'b0;
      r_render_data  <= '0;
      r_game_ack     <= 1'b0;
      r_game_rdata   <= '0;
      r_wait_cnt     <= '0;
      r_max_wait     <= '0;
      r_mem_addr     <= '0;
      r_mem_we       <= 1'b0;
      r_mem_wdata    <= '0;
    end else begin
      r_rtag0        <= 1'b0;
      r_gtag0        <= 1'b0;
      r_mem_we       <= 1'b0;
      r_game_ack     <= 1'b0;
      r_rtag1        <= r_rtag0;
      r_gtag1        <= r_gtag0;
      r_render_valid <= r_rtag1;
      if (r_rtag1) begin
        r_render_data <= i_mem_rdata;
      end

      if (w_render_grant) begin
        r_mem_addr <= i_render_addr;
        r_rtag0    <= 1'b1;
      end else if (w_game_grant) begin
        r_mem_addr <= i_game_addr;
        r_mem_we   <= i_game_we;
        r_gtag0    <= ~i_game_we;
        r_g_we     <= i_game_we;
        if (i_game_we) begin
          r_mem_wdata <= i_game_wdata;
        end
      end

      if (w_game_grant) begin
        if (r_wait_cnt > r_max_wait) begin
          r_max_wait <= r_wait_cnt;
        end
        r_wait_cnt <= '0;
      end else if (w_game_pend && (r_state == S_IDLE) && (r_wait_cnt != '1)) begin
        r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
      end

      case (r_state)
        S_IDLE: begin
          if (w_game_grant) begin
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (r_g_we) begin
            r_game_ack <= 1'b1;
            r_state    <= S_IDLE;
          end else begin
            r_state <= S_WAIT_RD;
          end
        end
        S_WAIT_RD: begin
          // The game slot tag marks the cycle the RAM returns the game's read.
          if (r_gtag1) begin
            r_game_ack   <= 1'b1;
            r_game_rdata <= i_mem_rdata;
            r_state      <= S_ACKED;
          end
        end
        S_ACKED: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_render_valid  = r_render_valid;
  assign o_render_data   = r_render_data;
  assign o_game_ack      = r_game_ack;
  assign o_game_rdata    = r_game_rdata;
  assign o_game_max_wait = r_max_wait;
  assign o_mem_addr      = r_mem_addr;
  assign o_mem_we        = r_mem_we;
  assign o_mem_wdata     = r_mem_wdata;

endmodule
`default_nettype wire
